rs_station: RTL

- Reservation station for ALU and branch instructions; the receiving end of the dispatch interface.
- Accepts one dispatched instruction per cycle into a free slot.
- Snoops the ALU and LSB broadcast buses to resolve pending source nicks.
- Issues the lowest-indexed ready entry to the ALU, one per cycle, through registered outputs.

---
 rtl/rs_station.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/rs_station.sv
// Reservation station for ALU/branch instructions.
// Accepts one dispatch per cycle into the lowest free slot, snoops the ALU and
// LSB broadcast buses to resolve pending source nicks, and issues the
// lowest-indexed ready entry through registered outputs.
module rs_station #(
    parameter int unsigned RS_SIZE = 16,
    parameter int unsigned NICK_W  = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned OP_W    = 6,
    parameter int unsigned IMM_W   = 32,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              iROB_clr,
    input  logic              iDP_en,
    input  logic              iDP_ls,
    input  logic [OP_W-1:0]   iDP_op,
    input  logic [ADDR_W-1:0] iDP_pc,
    input  logic [IMM_W-1:0]  iDP_imm,
    input  logic              iDP_pd,
    input  logic [NICK_W-1:0] iDP_rd_nick,
    input  logic [NICK_W-1:0] iDP_rs1_nick,
    input  logic [NICK_W-1:0] iDP_rs2_nick,
    input  logic [DATA_W-1:0] iDP_rs1_dt,
    input  logic [DATA_W-1:0] iDP_rs2_dt,
    input  logic              iALU_en,
    input  logic [NICK_W-1:0] iALU_nick,
    input  logic [DATA_W-1:0] iALU_dt,
    input  logic              iLSB_en,
    input  logic [NICK_W-1:0] iLSB_nick,
    input  logic [DATA_W-1:0] iLSB_dt,
    output logic              oRS_full,
    output logic              oRS_en,
    output logic [OP_W-1:0]   oRS_op,
    output logic [ADDR_W-1:0] oRS_pc,
    output logic [IMM_W-1:0]  oRS_imm,
    output logic              oRS_pd,
    output logic [NICK_W-1:0] oRS_rd_nick,
    output logic [DATA_W-1:0] oRS_rs1_dt,
    output logic [DATA_W-1:0] oRS_rs2_dt
);

    localparam int unsigned IDX_W = $clog2(RS_SIZE);

    // Entry storage
    logic [RS_SIZE-1:0] valid;
    logic [OP_W-1:0]    op_q       [RS_SIZE];
    logic [ADDR_W-1:0]  pc_q       [RS_SIZE];
    logic [IMM_W-1:0]   imm_q      [RS_SIZE];
    logic               pd_q       [RS_SIZE];
    logic [NICK_W-1:0]  rd_nick_q  [RS_SIZE];
    logic [NICK_W-1:0]  rs1_nick_q [RS_SIZE];
    logic [DATA_W-1:0]  rs1_dt_q   [RS_SIZE];
    logic [NICK_W-1:0]  rs2_nick_q [RS_SIZE];
    logic [DATA_W-1:0]  rs2_dt_q   [RS_SIZE];

    // Post-wakeup source state per entry
    logic [NICK_W-1:0]  wk_rs1_nick [RS_SIZE];
    logic [DATA_W-1:0]  wk_rs1_dt   [RS_SIZE];
    logic [NICK_W-1:0]  wk_rs2_nick [RS_SIZE];
    logic [DATA_W-1:0]  wk_rs2_dt   [RS_SIZE];

    // Dispatch sources after same-cycle broadcast bypass
    logic [NICK_W-1:0]  ins_rs1_nick;
    logic [DATA_W-1:0]  ins_rs1_dt;
    logic [NICK_W-1:0]  ins_rs2_nick;
    logic [DATA_W-1:0]  ins_rs2_dt;

    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               iss_found;
    logic [IDX_W-1:0]   iss_idx;
    logic               do_insert;

    // Full flag straight from registered valid bits
    always_comb begin
        oRS_full = &valid;
    end

    // Lowest free slot and lowest ready entry, both from registered state
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        iss_found  = 1'b0;
        iss_idx    = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (!free_found && !valid[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (!iss_found && valid[i] && (rs1_nick_q[i] == '0) && (rs2_nick_q[i] == '0)) begin
                iss_found = 1'b1;
                iss_idx   = IDX_W'(i);
            end
        end
    end

    // Accept a dispatch only when it targets this block and a slot is free
    always_comb begin
        do_insert = iDP_en && !iDP_ls && !oRS_full;
    end

    // Capture a broadcast that lands in the same cycle as the dispatch
    always_comb begin
        ins_rs1_nick = iDP_rs1_nick;
        ins_rs1_dt   = iDP_rs1_dt;
        ins_rs2_nick = iDP_rs2_nick;
        ins_rs2_dt   = iDP_rs2_dt;
        if (iDP_rs1_nick != '0) begin
            if (iALU_en && (iALU_nick == iDP_rs1_nick)) begin
                ins_rs1_nick = '0;
                ins_rs1_dt   = iALU_dt;
            end else if (iLSB_en && (iLSB_nick == iDP_rs1_nick)) begin
                ins_rs1_nick = '0;
                ins_rs1_dt   = iLSB_dt;
            end
        end
        if (iDP_rs2_nick != '0) begin
            if (iALU_en && (iALU_nick == iDP_rs2_nick)) begin
                ins_rs2_nick = '0;
                ins_rs2_dt   = iALU_dt;
            end else if (iLSB_en && (iLSB_nick == iDP_rs2_nick)) begin
                ins_rs2_nick = '0;
                ins_rs2_dt   = iLSB_dt;
            end
        end
    end

    // Resolve pending sources of valid entries from the broadcast buses
    always_comb begin
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            wk_rs1_nick[i] = rs1_nick_q[i];
            wk_rs1_dt[i]   = rs1_dt_q[i];
            wk_rs2_nick[i] = rs2_nick_q[i];
            wk_rs2_dt[i]   = rs2_dt_q[i];
            if (valid[i] && (rs1_nick_q[i] != '0)) begin
                if (iALU_en && (iALU_nick == rs1_nick_q[i])) begin
                    wk_rs1_nick[i] = '0;
                    wk_rs1_dt[i]   = iALU_dt;
                end else if (iLSB_en && (iLSB_nick == rs1_nick_q[i])) begin
                    wk_rs1_nick[i] = '0;
                    wk_rs1_dt[i]   = iLSB_dt;
                end
            end
            if (valid[i] && (rs2_nick_q[i] != '0)) begin
                if (iALU_en && (iALU_nick == rs2_nick_q[i])) begin
                    wk_rs2_nick[i] = '0;
                    wk_rs2_dt[i]   = iALU_dt;
                end else if (iLSB_en && (iLSB_nick == rs2_nick_q[i])) begin
                    wk_rs2_nick[i] = '0;
                    wk_rs2_dt[i]   = iLSB_dt;
                end
            end
        end
    end

    // State update: flush, hold on !rdy, otherwise wakeup + issue + insert.
    // The insert slot is always invalid and the issue slot always valid, so
    // the two never collide; the insert write follows the wakeup write so it
    // overrides whatever the wakeup loop computed for that (empty) slot.
    always_ff @(posedge clk) begin
        if (rst || iROB_clr) begin
            valid       <= '0;
            oRS_en      <= 1'b0;
            oRS_op      <= '0;
            oRS_pc      <= '0;
            oRS_imm     <= '0;
            oRS_pd      <= 1'b0;
            oRS_rd_nick <= '0;
            oRS_rs1_dt  <= '0;
            oRS_rs2_dt  <= '0;
        end else if (rdy) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                rs1_nick_q[i] <= wk_rs1_nick[i];
                rs1_dt_q[i]   <= wk_rs1_dt[i];
                rs2_nick_q[i] <= wk_rs2_nick[i];
                rs2_dt_q[i]   <= wk_rs2_dt[i];
            end

            if (iss_found) begin
                valid[iss_idx] <= 1'b0;
                oRS_en         <= 1'b1;
                oRS_op         <= op_q[iss_idx];
                oRS_pc         <= pc_q[iss_idx];
                oRS_imm        <= imm_q[iss_idx];
                oRS_pd         <= pd_q[iss_idx];
                oRS_rd_nick    <= rd_nick_q[iss_idx];
                oRS_rs1_dt     <= rs1_dt_q[iss_idx];
                oRS_rs2_dt     <= rs2_dt_q[iss_idx];
            end else begin
                oRS_en      <= 1'b0;
                oRS_op      <= '0;
                oRS_pc      <= '0;
                oRS_imm     <= '0;
                oRS_pd      <= 1'b0;
                oRS_rd_nick <= '0;
                oRS_rs1_dt  <= '0;
                oRS_rs2_dt  <= '0;
            end

            if (do_insert) begin
                valid[free_idx]      <= 1'b1;
                op_q[free_idx]       <= iDP_op;
                pc_q[free_idx]       <= iDP_pc;
                imm_q[free_idx]      <= iDP_imm;
                pd_q[free_idx]       <= iDP_pd;
                rd_nick_q[free_idx]  <= iDP_rd_nick;
                rs1_nick_q[free_idx] <= ins_rs1_nick;
                rs1_dt_q[free_idx]   <= ins_rs1_dt;
                rs2_nick_q[free_idx] <= ins_rs2_nick;
                rs2_dt_q[free_idx]   <= ins_rs2_dt;
            end
        end
    end

endmodule
